// File: rtl/cpu_pkg.sv
// Shared CPU definitions: TIMER opcode, instruction field positions and timer widths.
package cpu_pkg;

  localparam logic [5:0] OP_TIMER = 6'b101001;

  // Field positions within the 10 low instruction bits carried on cfg_data
  localparam int TMR_EN_BIT   = 9;
  localparam int TMR_BASE_MSB = 8;
  localparam int TMR_BASE_LSB = 6;
  localparam int TMR_THR_MSB  = 5;
  localparam int TMR_THR_LSB  = 0;

  localparam int THR_W  = 6;
  localparam int BASE_W = 3;
  localparam int PRE_W  = 7;

endpackage

// File: rtl/timer_prescaler.sv
// Divides clk by 2^base: tick pulses for one cycle when the counter reaches 2^base-1.
module timer_prescaler
  import cpu_pkg::*;
#(
  parameter int P_BASE_W = BASE_W,
  parameter int P_PRE_W  = PRE_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  input  logic                enable,
  input  logic [P_BASE_W-1:0] base,
  output logic                tick
);

  logic [P_PRE_W-1:0] pre_q, pre_d;
  logic [P_PRE_W-1:0] limit;

  // 2^base-1 as a mask; P_PRE_W >= 2^P_BASE_W-1 keeps it in range
  assign limit = ~({P_PRE_W{1'b1}} << base);

  always_comb begin
    tick  = 1'b0;
    pre_d = pre_q;
    if (clear) begin
      pre_d = '0;
    end else if (enable) begin
      if (pre_q == limit) begin
        tick  = 1'b1;
        pre_d = '0;
      end else begin
        pre_d = pre_q + P_PRE_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pre_q <= '0;
    else        pre_q <= pre_d;
  end

endmodule

// File: rtl/timer_irq_unit.sv
// Interval timer for the TIMER instruction: latches config, counts prescaled ticks
// to a threshold and raises a sticky level interrupt held until irq_ack.
module timer_irq_unit
  import cpu_pkg::*;
#(
  parameter int P_THR_W  = THR_W,
  parameter int P_BASE_W = BASE_W,
  parameter int P_PRE_W  = PRE_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_we,
  input  logic [9:0]         cfg_data,
  input  logic               irq_ack,
  output logic               irq,
  output logic               overrun,
  output logic               running,
  output logic [P_THR_W-1:0] count
);

  // Handshake: cfg_we and irq_ack are single-cycle strobes sampled at the rising
  // edge; irq is a level held from the expiry edge until an edge with irq_ack=1,
  // except that an expiry on the same edge as irq_ack keeps irq set.

  logic [P_BASE_W-1:0] base_q, base_d;
  logic [P_THR_W-1:0]  thr_q, thr_d;
  logic [P_THR_W-1:0]  count_q, count_d;
  logic                running_q, running_d;
  logic                irq_q, irq_d;
  logic                overrun_q, overrun_d;
  logic                tick;
  logic                expire;

  timer_prescaler #(
    .P_BASE_W (P_BASE_W),
    .P_PRE_W  (P_PRE_W)
  ) u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .clear  (cfg_we),
    .enable (running_q),
    .base   (base_q),
    .tick   (tick)
  );

  assign expire = tick && (count_q == thr_q);

  always_comb begin
    base_d    = base_q;
    thr_d     = thr_q;
    running_d = running_q;
    count_d   = count_q;
    if (cfg_we) begin
      base_d    = cfg_data[TMR_BASE_MSB:TMR_BASE_LSB];
      thr_d     = cfg_data[TMR_THR_MSB:TMR_THR_LSB];
      running_d = cfg_data[TMR_EN_BIT];
      count_d   = '0;
    end else if (tick) begin
      count_d = expire ? '0 : count_q + P_THR_W'(1);
    end
  end

  // A fresh expiry outranks a simultaneous ack, so the new event is not lost
  always_comb begin
    irq_d     = irq_q;
    overrun_d = overrun_q;
    if (irq_ack) begin
      irq_d     = 1'b0;
      overrun_d = 1'b0;
    end
    if (expire) begin
      irq_d = 1'b1;
      if (irq_q && !irq_ack) overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      base_q    <= '0;
      thr_q     <= '0;
      count_q   <= '0;
      running_q <= 1'b0;
      irq_q     <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      base_q    <= base_d;
      thr_q     <= thr_d;
      count_q   <= count_d;
      running_q <= running_d;
      irq_q     <= irq_d;
      overrun_q <= overrun_d;
    end
  end

  assign irq     = irq_q;
  assign overrun = overrun_q;
  assign running = running_q;
  assign count   = count_q;

endmodule

// File: doc/timer_irq_unit.md
Name: timer_irq_unit

Overview:
Programmable interval timer that executes the control unit's TIMER instruction, opcode 101001. The instruction layout is opcode[6] + enable[1] + base[3] + umbral[6]. The unit latches the configuration, divides clk by 2^base, counts prescaled ticks up to the threshold, and raises a level interrupt request. That request drives one of the control unit's interrupt inputs (ie1). The request is held until the CPU acknowledges it.

Parameters:
THR_W, 6, threshold/count width (umbral field)
BASE_W, 3, prescaler exponent width (base field)
PRE_W, 7, prescaler counter width; must be >= 2^BASE_W - 1

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
cfg_we  in  1  one-cycle strobe: TIMER instruction decoded this cycle
cfg_data  in  10  instruction bits [9:0]: [9]=enable, [8:6]=base, [5:0]=threshold
irq_ack  in  1  one-cycle acknowledge from CPU interrupt entry
irq  out  1  interrupt request (level, sticky until ack)
overrun  out  1  sticky: an expiry occurred while irq was already pending
running  out  1  timer enabled and counting
count  out  THR_W  current tick count (debug/readback)

Behaviour:
- Reset (reset=0, asynchronous): all of the following are cleared.
  - Outputs: irq=0, overrun=0, running=0, count=0.
  - Internal state: prescaler=0, base_r=0, thr_r=0.
- Configuration write (cfg_we=1 at an edge):
  - base_r is loaded from cfg_data[8:6], thr_r from cfg_data[5:0], and running from cfg_data[9].
  - prescaler and count are cleared. This happens regardless of the previous state, so a write while running is a restart.
  - irq and overrun are not affected by cfg_we.
  - No tick is evaluated at the edge where cfg_we=1.
- Tick generation:
  - While running=1 and cfg_we=0, tick=1 when prescaler == 2^base_r - 1.
  - On tick, prescaler is set to 0; otherwise prescaler increments.
  - base_r=0 gives a tick every cycle; base_r=7 gives a tick every 128 cycles.
- Counting:
  - On tick, if count == thr_r then count goes to 0 and the expire event fires. Otherwise count increments.
  - Period = (thr_r+1) * 2^base_r cycles.
  - thr_r=0 means expiry on every tick.
  - count never exceeds thr_r, so there is no wrap past 2^THR_W - 1.
- Interrupt:
  - Expire sets irq=1 at the same edge.
  - irq_ack=1 clears irq and overrun.
  - If expire and irq_ack fall on the same edge, irq stays 1 (the new event wins) and overrun is not set.
  - Expire with irq=1 and irq_ack=0 sets overrun=1; irq stays 1.
- Disable:
  - cfg_we with enable=0 stops counting: running=0, count=0, prescaler=0.
  - A pending irq and overrun stay set until acknowledged.
- irq_ack while irq=0 has no effect.
- Latency: cfg_we at edge N with base=0, thr=2 gives count=1 after N+1, count=2 after N+2, then count=0 and irq=1 after N+3.
- Reset asserted mid-count or with irq pending: everything clears immediately. After release the timer is idle until the next cfg_we.

Decomposition:
- Shared package cpu_pkg:
  - OP_TIMER = 6'b101001
  - field positions: TMR_EN_BIT=9, TMR_BASE_MSB=8, TMR_BASE_LSB=6, TMR_THR_MSB=5, TMR_THR_LSB=0
  - THR_W and BASE_W defaults
- One natural sub-module: timer_prescaler. Inputs: clk, reset, clear, enable, base. Output: tick. It contains the PRE_W counter and the compare against 2^base-1.
- Threshold counter, irq/overrun logic and configuration registers stay in timer_irq_unit.

Test Plan:
- Reset then idle: hold reset=0 for 3 cycles, release, run 50 cycles with no cfg_we -> irq=0, running=0, count=0 throughout.
- Basic period: cfg_data=10'b1_000_000010 (en=1, base=0, thr=2) -> irq rises 3 edges after the cfg_we edge. Ack the next cycle, then irq re-rises every 3 cycles.
- Prescale: cfg_data=10'b1_011_000001 (base=3, thr=1) -> first irq 16 cycles after cfg_we. count steps 0->1 at cycle 8 and 1->0 at cycle 16.
- Overrun and simultaneous ack: base=0, thr=0, never ack -> irq=1 after the first cycle and overrun=1 after the second. Ack on an expiry edge -> irq stays 1 and overrun is 0.
- Disable/restart: mid-count (count=3, thr=5), write en=0 -> running=0 and count=0 next cycle, and an already pending irq stays 1. Rewrite en=1 mid-period -> count restarts from 0 with the full period.
- Async reset mid-operation: assert reset between edges while irq=1 and count=4 -> irq=0 and count=0 immediately, without waiting for a clk edge.
